// File: rtl/vga_tile_pattern.sv
// Tile-grid colour generator: splits the active area into TILES_X x TILES_Y tiles with
// LFSR-jittered boundaries and refreshes the per-tile palette only at frame boundaries.
module vga_tile_pattern #(
  parameter int          COLOR_W   = 4,
  parameter int          H_ACTIVE  = 1280,
  parameter int          V_ACTIVE  = 960,
  parameter int          TILES_X   = 2,
  parameter int          TILES_Y   = 2,
  parameter int          JITTER_W  = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               display_en,
  input  logic [11:0]        h_count,
  input  logic [11:0]        v_count,
  input  logic               update_req,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               busy
);
  localparam int N     = TILES_X * TILES_Y;
  localparam int RGB_W = 3 * COLOR_W;
  localparam int TW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int RW    = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

  typedef enum logic {IDLE, REFRESH} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [TW-1:0]       k_q, k_d;
  logic                pending_q, pending_d;
  logic [RGB_W-1:0]    palette_q [N];
  logic [RGB_W-1:0]    palette_d [N];
  logic [JITTER_W-1:0] jx_q [TILES_X];
  logic [JITTER_W-1:0] jx_d [TILES_X];
  logic [JITTER_W-1:0] jy_q [TILES_Y];
  logic [JITTER_W-1:0] jy_d [TILES_Y];

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                hbnd_q, hbnd_d;
  logic                vbnd_q, vbnd_d;
  logic [TW-1:0]       tile_p1_q, tile_p1_d;
  logic                de_p1_q, de_p1_d;
  logic [RGB_W-1:0]    rgb_p2_q, rgb_p2_d;

  logic [11:0]         xs_w [TILES_X];
  logic [11:0]         ys_w [TILES_Y];
  logic                fb, eff_pending, trigger;

  // Boundary positions: elaboration-time tile edges pulled left/up by the jitter.
  for (genvar i = 0; i < TILES_X; i++) begin : g_xs
    assign xs_w[i] = 12'((i + 1) * H_ACTIVE / TILES_X) - 12'(jx_q[i]);
  end
  for (genvar j = 0; j < TILES_Y; j++) begin : g_ys
    assign ys_w[j] = 12'((j + 1) * V_ACTIVE / TILES_Y) - 12'(jy_q[j]);
  end

  assign busy = (state_q == REFRESH);
  assign fb   = (v_count == 12'(V_ACTIVE)) && (h_count == 12'd0);

  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    eff_pending = pending_q | (update_req & (mode != 2'd0));
    trigger     = fb & ~busy & ((mode == 2'd2) | eff_pending);
    pending_d   = trigger ? 1'b0 : eff_pending;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    palette_d = palette_q;
    jx_d      = jx_q;
    jy_d      = jy_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = REFRESH;
          k_d     = '0;
        end
      end
      REFRESH: begin
        for (int i = 0; i < N; i++)
          if (int'(k_q) == i) palette_d[i] = lfsr_q[RGB_W-1:0];
        for (int i = 0; i < TILES_X - 1; i++)
          if (int'(k_q) == i) jx_d[i] = lfsr_q[15 -: JITTER_W];
        for (int i = 0; i < TILES_Y - 1; i++)
          if (int'(k_q) == i) jy_d[i] = lfsr_q[JITTER_W-1:0];
        if (int'(k_q) == N - 1) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: col/row of the current pixel; a boundary hit on pixel h moves col from h+1,
  // a hit on line v moves row from line v+1.
  always_comb begin
    col_d  = (h_count == 12'd0) ? '0 : (hbnd_q ? col_q + 1'b1 : col_q);
    hbnd_d = (h_count == xs_w[col_d]) && (int'(col_d) < TILES_X - 1);
    row_d  = row_q;
    vbnd_d = vbnd_q;
    if (h_count == 12'd0) begin
      row_d  = (v_count == 12'd0) ? '0 : (vbnd_q ? row_q + 1'b1 : row_q);
      vbnd_d = (v_count == ys_w[row_d]) && (int'(row_d) < TILES_Y - 1);
    end
    tile_p1_d = (mode == 2'd3) ? '0 : TW'(int'(row_d) * TILES_X + int'(col_d));
    de_p1_d   = display_en;
  end

  // Stage 2: palette lookup, blanked outside the active area.
  always_comb begin
    rgb_p2_d = de_p1_q ? palette_q[tile_p1_q] : '0;
  end

  assign {r_out, g_out, b_out} = rgb_p2_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      k_q       <= '0;
      pending_q <= 1'b1;
      palette_q <= '{default: '0};
      jx_q      <= '{default: '0};
      jy_q      <= '{default: '0};
      col_q     <= '0;
      row_q     <= '0;
      hbnd_q    <= 1'b0;
      vbnd_q    <= 1'b0;
      tile_p1_q <= '0;
      de_p1_q   <= 1'b0;
      rgb_p2_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      palette_q <= palette_d;
      jx_q      <= jx_d;
      jy_q      <= jy_d;
      col_q     <= col_d;
      row_q     <= row_d;
      hbnd_q    <= hbnd_d;
      vbnd_q    <= vbnd_d;
      tile_p1_q <= tile_p1_d;
      de_p1_q   <= de_p1_d;
      rgb_p2_q  <= rgb_p2_d;
    end
  end
endmodule

// File: tb/tb_vga_tile_pattern.sv
// Scoreboard bench for vga_tile_pattern on a small 4x3 grid with a reduced raster.
module tb_vga_tile_pattern;
  localparam int C  = 4;
  localparam int HA = 40;
  localparam int VA = 30;
  localparam int HT = 48;
  localparam int VT = 36;
  localparam int TX = 4;
  localparam int TY = 3;
  localparam int JW = 3;
  localparam int N  = TX * TY;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         reset = 1'b1, display_en = 1'b0, update_req = 1'b0, busy;
  logic [11:0]  h_count = '0, v_count = '0;
  logic [1:0]   mode = 2'd1;
  logic [C-1:0] r_out, g_out, b_out;

  vga_tile_pattern #(.COLOR_W(C), .H_ACTIVE(HA), .V_ACTIVE(VA), .TILES_X(TX),
                     .TILES_Y(TY), .JITTER_W(JW), .LFSR_SEED(SEED)) dut (
    .clk_in(clk_in), .reset(reset), .display_en(display_en), .h_count(h_count),
    .v_count(v_count), .update_req(update_req), .mode(mode), .r_out(r_out),
    .g_out(g_out), .b_out(b_out), .busy(busy));

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic [11:0] rgb; int h; int v;} exp_t;
  exp_t sb[$];

  logic [15:0] m_lfsr;
  bit          m_busy, m_pending, armed = 0;
  int          m_k, busy_cnt;
  logic [11:0] m_pal [N];
  int          m_jx [TX];
  int          m_jy [TY];
  logic [11:0] cap0, cap5;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [11:0] exp_pix(input int h, input int v, input logic [1:0] md, input bit de);
    int col = 0, row = 0;
    if (!de) return 12'h000;
    for (int i = 0; i < TX - 1; i++) if (h > (i + 1) * HA / TX - m_jx[i]) col++;
    for (int j = 0; j < TY - 1; j++) if (v > (j + 1) * VA / TY - m_jy[j]) row++;
    return (md == 2'd3) ? m_pal[0] : m_pal[row * TX + col];
  endfunction

  task automatic model_edge(input int h, input int v, input bit rst, input bit upd);
    bit fb, eff, trig;
    if (rst) begin
      m_lfsr = SEED; m_busy = 0; m_k = 0; m_pending = 1;
      foreach (m_pal[i]) m_pal[i] = '0;
      foreach (m_jx[i]) m_jx[i] = 0;
      foreach (m_jy[i]) m_jy[i] = 0;
      return;
    end
    fb   = (v == VA) && (h == 0);
    eff  = m_pending || (upd && mode != 2'd0);
    trig = fb && !m_busy && (mode == 2'd2 || eff);
    if (m_busy) begin
      m_pal[m_k] = m_lfsr[11:0];
      if (m_k < TX - 1) m_jx[m_k] = int'(m_lfsr[15:13]);
      if (m_k < TY - 1) m_jy[m_k] = int'(m_lfsr[2:0]);
      if (m_k == N - 1) m_busy = 0;
      else m_k++;
    end
    m_pending = trig ? 1'b0 : eff;
    if (trig) begin m_busy = 1; m_k = 0; end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic step(input int h, input int v, input bit rst, input bit upd);
    exp_t e;
    logic [11:0] obs;
    bit de;
    @(negedge clk_in);
    obs = {r_out, g_out, b_out};
    if (armed) begin
      check_eq("busy", 32'(busy), 32'(m_busy));
      if (busy === 1'b1) busy_cnt++;
    end
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_eq($sformatf("rgb h%0d v%0d", e.h, e.v), 32'(obs), 32'(e.rgb));
      if (e.h == 2 && e.v == 2) cap0 = obs;
      if (e.h == 12 && e.v == 12) cap5 = obs;
    end
    de = (h < HA) && (v < VA);
    reset = rst; h_count = 12'(h); v_count = 12'(v); display_en = de; update_req = upd;
    if (rst) begin
      sb.delete();
      sb.push_back('{12'h000, -1, -1});
      sb.push_back('{12'h000, -1, -1});
    end else begin
      sb.push_back('{exp_pix(h, v, mode, de), h, v});
    end
    @(posedge clk_in);
    model_edge(h, v, rst, upd);
    if (rst) armed = 1;
  endtask

  task automatic run_frame(input int upd_v, input int upd_h, input int rst_v, input int rst_h,
                           output int bc);
    busy_cnt = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++)
        step(h, v, (v == rst_v && h == rst_h), (v == upd_v && h == upd_h));
    bc = busy_cnt;
  endtask

  int bc;
  logic [11:0] c0_a, c5_a;

  initial begin
    mode = 2'd1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1;
    check_eq("rst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    run_frame(-1, -1, -1, -1, bc); check_eq("f0_busy_cycles", bc, N);
    check_eq("f0_black", 32'(cap0), 32'h0);
    run_frame(5, 5, -1, -1, bc);   check_eq("tempo_midframe_busy", bc, N);
    run_frame(VA, 0, -1, -1, bc);  check_eq("tempo_on_fb_busy", bc, N);
    run_frame(-1, -1, -1, -1, bc); check_eq("tempo_pending_clear", bc, 0);

    mode = 2'd2;
    run_frame(-1, -1, -1, -1, bc); check_eq("frame_mode_busy0", bc, N);
    run_frame(-1, -1, -1, -1, bc); check_eq("frame_mode_busy1", bc, N);
    c0_a = cap0; c5_a = cap5;
    run_frame(-1, -1, -1, -1, bc); check_eq("frame_mode_busy2", bc, N);
    check_eq("frame_palette_changes", 32'((cap0 != c0_a) || (cap5 != c5_a)), 32'h1);

    mode = 2'd3;
    run_frame(-1, -1, -1, -1, bc); check_eq("mono_busy", bc, 0);
    check_eq("mono_same_colour", 32'(cap0 == cap5), 32'h1);

    mode = 2'd0;
    run_frame(5, 5, -1, -1, bc);   check_eq("static_ignores_req", bc, 0);

    mode = 2'd1;
    run_frame(5, 5, VA, 3, bc);    check_eq("reset_abort_busy", bc, 3);
    run_frame(-1, -1, -1, -1, bc); check_eq("post_reset_refresh", bc, N);
    run_frame(-1, -1, -1, -1, bc); check_eq("post_reset_idle", bc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
